// File: rtl/branch_predictor_if.sv
// Branch predictor port bundle shared by the IF/ID stages and the predictor.
//
// Signals:
//   lookupPC        PC currently in IF
//   predTaken       prediction: redirect fetch to predTarget
//   predTarget      predicted next PC
//   updateEn        a branch/jump resolved in ID this cycle
//   updatePC        PC of the resolved instruction
//   updateTaken     actual outcome
//   updateIsJump    resolved instruction is JAL/JALR
//   updateTarget    actual target (meaningful when updateTaken=1)
//   clearEn         invalidate every entry at the next edge (fence.i)
//   mispredictCount saturating count of mispredictions
//
// Modports: master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int ADDR_SIZE = 32,
  parameter int CNT_WIDTH = 32
);
  logic [ADDR_SIZE-1:0] lookupPC;
  logic                 predTaken;
  logic [ADDR_SIZE-1:0] predTarget;
  logic                 updateEn;
  logic [ADDR_SIZE-1:0] updatePC;
  logic                 updateTaken;
  logic                 updateIsJump;
  logic [ADDR_SIZE-1:0] updateTarget;
  logic                 clearEn;
  logic [CNT_WIDTH-1:0] mispredictCount;

  modport master (
    output lookupPC, updateEn, updatePC, updateTaken, updateIsJump,
           updateTarget, clearEn,
    input  predTaken, predTarget, mispredictCount
  );

  modport slave (
    input  lookupPC, updateEn, updatePC, updateTaken, updateIsJump,
           updateTarget, clearEn,
    output predTaken, predTarget, mispredictCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// A combinational lookup port predicts the next fetch PC from the PC in IF;
// resolved branches/jumps from ID train the table through a second read
// port, and every misprediction bumps a saturating performance counter.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset (clears valid bits and the counter)
//   bus  branch_predictor_if.slave; its ADDR_SIZE/CNT_WIDTH must match the
//        parameters of this module
//
// Parameters: ADDR_SIZE (PC width), ENTRIES (power of two, >= 2),
//             CTR_BITS (direction counter width, >= 1), CNT_WIDTH.
module branch_predictor #(
  parameter int ADDR_SIZE = 32,
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bus
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_SIZE - IDX - 2;

  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  // Only the MSB set: the weakest counter value that still predicts taken.
  localparam logic [CTR_BITS-1:0]  CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);
  localparam logic [ADDR_SIZE-1:0] PC_STEP  = ADDR_SIZE'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // Only the valid bits carry reset; the rest is plain RAM-style storage
  // whose contents are ignored while the matching valid bit is low.
  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_mem    [ENTRIES];
  logic [ADDR_SIZE-1:0] target_mem [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_mem    [ENTRIES];
  logic [CNT_WIDTH-1:0] count_q;

  // Lookup port
  logic [IDX-1:0]   look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic             look_taken;

  assign look_idx   = bus.lookupPC[IDX+1:2];
  assign look_tag   = bus.lookupPC[ADDR_SIZE-1:IDX+2];
  assign look_hit   = valid_q[look_idx] && (tag_mem[look_idx] == look_tag);
  assign look_taken = look_hit && ctr_mem[look_idx][CTR_BITS-1];

  assign bus.predTaken  = look_taken;
  assign bus.predTarget = look_taken ? target_mem[look_idx]
                                     : bus.lookupPC + PC_STEP;

  // Update port: reads the pre-update state of the resolved PC's entry
  logic [IDX-1:0]       upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_hit;
  logic [CTR_BITS-1:0]  upd_ctr;
  logic [ADDR_SIZE-1:0] upd_target;
  logic                 upd_pred_taken;
  logic                 mispredict;

  assign upd_idx        = bus.updatePC[IDX+1:2];
  assign upd_tag        = bus.updatePC[ADDR_SIZE-1:IDX+2];
  assign upd_hit        = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_ctr        = ctr_mem[upd_idx];
  assign upd_target     = target_mem[upd_idx];
  assign upd_pred_taken = upd_hit && upd_ctr[CTR_BITS-1];

  // Wrong direction, or right "taken" direction but to the wrong place.
  assign mispredict = bus.updateEn &&
                      ((upd_pred_taken != bus.updateTaken) ||
                       (upd_pred_taken && bus.updateTaken &&
                        (upd_target != bus.updateTarget)));

  // Word-alignment bits never select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookupPC[1:0], bus.updatePC[1:0]};

  // Next contents of the indexed entry. A hit trains the counter; a taken
  // miss allocates over whatever lived at that index (aliasing replaces).
  // A clear in the same cycle drops the table write entirely.
  logic                 write_entry;
  logic [CTR_BITS-1:0]  ctr_next;
  logic [ADDR_SIZE-1:0] target_next;

  always_comb begin
    write_entry = 1'b0;
    ctr_next    = upd_ctr;
    target_next = upd_target;
    if (bus.updateEn && !bus.clearEn) begin
      if (upd_hit) begin
        write_entry = 1'b1;
        if (bus.updateIsJump) begin
          ctr_next    = CTR_MAX;
          target_next = bus.updateTarget;
        end else if (bus.updateTaken) begin
          ctr_next    = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + 1'b1;
          target_next = bus.updateTarget;
        end else begin
          ctr_next    = (upd_ctr == '0) ? upd_ctr : upd_ctr - 1'b1;
        end
      end else if (bus.updateTaken) begin
        write_entry = 1'b1;
        ctr_next    = bus.updateIsJump ? CTR_MAX : CTR_WEAK;
        target_next = bus.updateTarget;
      end
    end
  end

  // Entry payload storage, no reset.
  always_ff @(posedge clk) begin
    if (rst && write_entry) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= target_next;
      ctr_mem[upd_idx]    <= ctr_next;
    end
  end

  // Valid bits: cleared by reset or fence.i, set on allocation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (bus.clearEn) begin
      valid_q <= '0;
    end else if (write_entry) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Mispredict counter, sticks at all ones; still counts during a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (mispredict && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.mispredictCount = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. Two instances share all stimulus:
//   dut0: ENTRIES=16, CTR_BITS=2, CNT_WIDTH=32
//   dut1: ENTRIES=16, CTR_BITS=1, CNT_WIDTH=4
// A driver issues one cycle of stimulus, pushes the expected outputs of both
// instances (from a behavioural table model) into a scoreboard queue, and a
// monitor pops and compares on the falling edge.
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_SIZE(32), .CNT_WIDTH(32)) bus0 ();
  branch_predictor_if #(.ADDR_SIZE(32), .CNT_WIDTH(4))  bus1 ();

  branch_predictor #(.ADDR_SIZE(32), .ENTRIES(ENTRIES), .CTR_BITS(2),
                     .CNT_WIDTH(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  branch_predictor #(.ADDR_SIZE(32), .ENTRIES(ENTRIES), .CTR_BITS(1),
                     .CNT_WIDTH(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    string       name;
    bit          taken0;
    logic [31:0] target0;
    longint      count0;
    bit          taken1;
    logic [31:0] target1;
    longint      count1;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: per instance, an array of entries holding plain numbers.
  bit          m_valid  [2][ENTRIES];
  longint      m_tag    [2][ENTRIES];
  logic [31:0] m_target [2][ENTRIES];
  int          m_ctr    [2][ENTRIES];
  longint      m_cnt    [2];

  function automatic int ctr_top(input int inst);
    return (inst == 0) ? 3 : 1;
  endfunction

  function automatic longint cnt_top(input int inst);
    return (inst == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  function automatic int pc_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic longint pc_tag(input logic [31:0] pc);
    return longint'(pc / (4 * ENTRIES));
  endfunction

  function automatic void model_reset(input int inst);
    for (int i = 0; i < ENTRIES; i++) m_valid[inst][i] = 1'b0;
    m_cnt[inst] = 0;
  endfunction

  function automatic void model_predict(input int inst, input logic [31:0] pc,
                                        output bit hit, output bit taken,
                                        output logic [31:0] tgt);
    int idx;
    idx   = pc_index(pc);
    hit   = m_valid[inst][idx] && (m_tag[inst][idx] == pc_tag(pc));
    // Upper half of the counter range predicts taken.
    taken = hit && (2 * m_ctr[inst][idx] > ctr_top(inst));
    tgt   = taken ? m_target[inst][idx] : pc + 32'd4;
  endfunction

  function automatic void model_update(input int inst, input bit en,
                                       input logic [31:0] pc, input bit taken,
                                       input bit jump, input logic [31:0] target,
                                       input bit clr);
    bit          hit;
    bit          pt;
    logic [31:0] ptgt;
    int          idx;
    int          top;
    model_predict(inst, pc, hit, pt, ptgt);
    idx = pc_index(pc);
    top = ctr_top(inst);
    if (en && ((pt != taken) || (pt && taken && ptgt != target)))
      if (m_cnt[inst] < cnt_top(inst)) m_cnt[inst]++;
    if (clr) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[inst][i] = 1'b0;
      return;
    end
    if (!en) return;
    if (hit) begin
      if (jump) begin
        m_ctr[inst][idx]    = top;
        m_target[inst][idx] = target;
      end else if (taken) begin
        m_ctr[inst][idx]    = (m_ctr[inst][idx] < top) ? m_ctr[inst][idx] + 1 : top;
        m_target[inst][idx] = target;
      end else begin
        m_ctr[inst][idx]    = (m_ctr[inst][idx] > 0) ? m_ctr[inst][idx] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[inst][idx]  = 1'b1;
      m_tag[inst][idx]    = pc_tag(pc);
      m_target[inst][idx] = target;
      m_ctr[inst][idx]    = jump ? top : (top + 1) / 2;
    end
  endfunction

  task automatic check_output(input string name, input string field,
                              input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%0h expected=0x%0h",
               name, field, actual, expected);
    end
  endtask

  // One cycle of stimulus to both instances; expectations use the state
  // before this cycle's edge, then the model advances across that edge.
  task automatic apply_stimulus(input string name, input bit rst_val,
                                input logic [31:0] look_pc, input bit upd_en,
                                input logic [31:0] upd_pc, input bit upd_taken,
                                input bit upd_jump, input logic [31:0] upd_target,
                                input bit clr);
    exp_t        e;
    bit          hit;
    @(posedge clk);
    #1;
    rst = rst_val;
    bus0.lookupPC = look_pc;     bus1.lookupPC = look_pc;
    bus0.updateEn = upd_en;      bus1.updateEn = upd_en;
    bus0.updatePC = upd_pc;      bus1.updatePC = upd_pc;
    bus0.updateTaken = upd_taken;   bus1.updateTaken = upd_taken;
    bus0.updateIsJump = upd_jump;   bus1.updateIsJump = upd_jump;
    bus0.updateTarget = upd_target; bus1.updateTarget = upd_target;
    bus0.clearEn = clr;          bus1.clearEn = clr;
    if (!rst_val) begin
      model_reset(0);
      model_reset(1);
    end
    e.name = name;
    model_predict(0, look_pc, hit, e.taken0, e.target0);
    model_predict(1, look_pc, hit, e.taken1, e.target1);
    e.count0 = m_cnt[0];
    e.count1 = m_cnt[1];
    sb_q.push_back(e);
    if (rst_val) begin
      model_update(0, upd_en, upd_pc, upd_taken, upd_jump, upd_target, clr);
      model_update(1, upd_en, upd_pc, upd_taken, upd_jump, upd_target, clr);
    end
  endtask

  task automatic do_update(input string name, input logic [31:0] look_pc,
                           input logic [31:0] pc, input bit taken,
                           input bit jump, input logic [31:0] target);
    apply_stimulus(name, 1'b1, look_pc, 1'b1, pc, taken, jump, target, 1'b0);
  endtask

  task automatic do_idle(input string name, input logic [31:0] look_pc);
    apply_stimulus(name, 1'b1, look_pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output(e.name, "predTaken0",  longint'(bus0.predTaken),       longint'(e.taken0));
      check_output(e.name, "predTarget0", longint'(bus0.predTarget),      longint'(e.target0));
      check_output(e.name, "count0",      longint'(bus0.mispredictCount), e.count0);
      check_output(e.name, "predTaken1",  longint'(bus1.predTaken),       longint'(e.taken1));
      check_output(e.name, "predTarget1", longint'(bus1.predTarget),      longint'(e.target1));
      check_output(e.name, "count1",      longint'(bus1.mispredictCount), e.count1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0;
    bus0.lookupPC = '0; bus0.updateEn = 1'b0; bus0.updatePC = '0;
    bus0.updateTaken = 1'b0; bus0.updateIsJump = 1'b0;
    bus0.updateTarget = '0; bus0.clearEn = 1'b0;
    bus1.lookupPC = '0; bus1.updateEn = 1'b0; bus1.updatePC = '0;
    bus1.updateTaken = 1'b0; bus1.updateIsJump = 1'b0;
    bus1.updateTarget = '0; bus1.clearEn = 1'b0;
    model_reset(0);
    model_reset(1);
    $display("[TB] start");

    // Reset state
    apply_stimulus("reset_lookup", 1'b0, 32'h100, 1'b0, 0, 0, 0, 0, 1'b0);

    // Conditional branch training and decay
    do_update("alloc_40",   32'h40, 32'h40, 1'b1, 1'b0, 32'h80);
    do_update("nt1_40",     32'h40, 32'h40, 1'b0, 1'b0, 32'h0);
    do_update("nt2_40",     32'h40, 32'h40, 1'b0, 1'b0, 32'h0);
    do_idle  ("after_nt_40", 32'h40);

    // Saturation
    for (int i = 0; i < 6; i++) do_update($sformatf("sat_t%0d", i), 32'h40, 32'h40, 1'b1, 1'b0, 32'h80);
    do_update("sat_nt",  32'h40, 32'h40, 1'b0, 1'b0, 32'h0);
    do_idle  ("sat_look", 32'h40);

    // Aliasing at index 0
    do_update("alias_80",    32'h80, 32'h80, 1'b1, 1'b0, 32'h200);
    do_idle  ("alias_look40", 32'h40);
    do_idle  ("alias_look80", 32'h80);

    // Jump: same-cycle lookup sees old data, then retarget
    do_update("jal_alloc",  32'h10, 32'h10, 1'b1, 1'b1, 32'h400);
    do_idle  ("jal_look",    32'h10);
    do_update("jal_retgt",  32'h10, 32'h10, 1'b1, 1'b1, 32'h500);
    do_idle  ("jal_look2",   32'h10);

    // PC wrap on the fall-through target
    do_idle  ("wrap_look",   32'hFFFF_FFFC);

    // Clear together with a taken miss
    apply_stimulus("clear_upd", 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 32'h340, 1'b1);
    do_idle  ("clear_look300", 32'h300);
    do_idle  ("clear_look80",  32'h80);

    // Reset asserted between edges with a nonzero count
    do_update("pre_rst", 32'h20, 32'h20, 1'b1, 1'b0, 32'h900);
    apply_stimulus("mid_rst", 1'b0, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0, 32'h900, 1'b0);
    do_idle  ("post_rst", 32'h20);

    // 20 mispredicting jumps: the 4-bit counter must stop at 15
    for (int i = 0; i < 20; i++)
      do_update($sformatf("cnt_sat%0d", i), 32'h800, 32'h800, 1'b1, 1'b1,
                (i % 2 == 0) ? 32'h1000 : 32'h2000);
    do_idle("cnt_sat_end", 32'h800);

    // Randomized traffic over a small PC pool so hits and aliasing are common
    for (int i = 0; i < 400; i++) begin
      bit          r_rst;
      bit          r_en;
      bit          r_taken;
      bit          r_jump;
      bit          r_clr;
      logic [31:0] r_look;
      logic [31:0] r_pc;
      logic [31:0] r_tgt;
      r_rst   = ($urandom_range(0, 99) != 0);
      r_en    = ($urandom_range(0, 3) != 0);
      r_jump  = ($urandom_range(0, 3) == 0);
      r_taken = r_jump || ($urandom_range(0, 1) == 1);
      r_clr   = ($urandom_range(0, 40) == 0);
      r_pc    = 32'($urandom_range(0, 63)) * 32'd4;
      r_look  = ($urandom_range(0, 1) == 1) ? r_pc : 32'($urandom_range(0, 63)) * 32'd4;
      r_tgt   = 32'($urandom_range(0, 7)) * 32'h100;
      apply_stimulus($sformatf("rand%0d", i), r_rst, r_look, r_en, r_pc,
                     r_taken, r_jump, r_tgt, r_clr);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("end", "queue_empty", longint'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
